osd_mam_sram_resp: RTL and testbench

Memory-side responder for the MAM memory-access interface. It accepts single-beat and burst read and write requests issued by the MAM, and executes them on a single-port synchronous SRAM with 1-cycle read latency. It sits between the MAM's `req_*`/`write_*`/`read_*` port group and the on-chip memory macro, on the debug clock domain.

---
 rtl/osd_mam_sram_resp.sv | 163 ++++++++++++++++
 tb/tb_osd_mam_sram_resp.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_mam_sram_resp.sv
// MAM memory-side responder: executes single/burst MAM reads and writes on a 1-cycle SRAM.
// Optional `OSD_MAM_SRAM_BOUNDS_EN suppresses SRAM accesses to words outside the memory.
module osd_mam_sram_resp #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned ADDR_BASE  = 0,
  parameter int unsigned AW         = $clog2(MEM_SIZE + ADDR_BASE),
  localparam int unsigned BW        = DATA_WIDTH / 8,
  localparam int unsigned WAW       = $clog2(MEM_SIZE / BW)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_rw_i,
  input  logic [AW-1:0]         req_addr_i,
  input  logic                  req_burst_i,
  input  logic [15:0]           req_size_i,
  input  logic                  write_valid_i,
  input  logic [DATA_WIDTH-1:0] write_data_i,
  input  logic [BW-1:0]         write_strb_i,
  output logic                  write_ready_o,
  output logic                  read_valid_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  input  logic                  read_ready_i,
  output logic                  sram_ce_o,
  output logic                  sram_we_o,
  output logic [WAW-1:0]        sram_addr_o,
  output logic [BW-1:0]         sram_be_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

  localparam int unsigned LBW = $clog2(BW);
`ifdef OSD_MAM_SRAM_BOUNDS_EN
  // One extra bit keeps addresses below ADDR_BASE distinguishable from in-range ones.
  localparam int unsigned XW = AW + 1;
`else
  localparam int unsigned XW = WAW;
`endif

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         waddr_q, waddr_d;
  logic [15:0]           remaining_q, remaining_d;
  logic                  burst_q, burst_d;
  logic                  inflight_q, inflight_zero_q;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic                  rd_ptr_q, wr_ptr_q;
  logic [1:0]            count_q, count_d;
  logic                  push, pop, issue, slot_free, in_range;
  logic [DATA_WIDTH-1:0] push_data;

`ifdef OSD_MAM_SRAM_BOUNDS_EN
  assign in_range = (waddr_q < XW'(MEM_SIZE / BW));
`else
  assign in_range = 1'b1;
`endif

  assign push         = inflight_q;
  assign push_data    = inflight_zero_q ? '0 : sram_rdata_i;
  assign read_valid_o = (count_q != 2'd0);
  assign read_data_o  = fifo_q[rd_ptr_q];
  assign pop          = read_valid_o & read_ready_i;

  // Room for one more beat counting the pending return and a same-cycle pop.
  assign slot_free = (count_q == 2'd0) ||
                     (count_q == 2'd1 && (!inflight_q || pop)) ||
                     (count_q == 2'd2 && pop && !inflight_q);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    waddr_d       = waddr_q;
    remaining_d   = remaining_q;
    burst_d       = burst_q;
    issue         = 1'b0;
    req_ready_o   = 1'b0;
    write_ready_o = 1'b0;
    sram_ce_o     = 1'b0;
    sram_we_o     = 1'b0;
    sram_addr_o   = '0;
    sram_be_o     = '0;
    sram_wdata_o  = '0;
    case (state_q)
      StIdle: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          waddr_d     = XW'(({1'b0, req_addr_i} - (AW + 1)'(ADDR_BASE)) >> LBW);
          remaining_d = (!req_burst_i || req_size_i == 16'd0) ? 16'd1 : req_size_i;
          burst_d     = req_burst_i;
          state_d     = req_rw_i ? StWrite : StRead;
        end
      end
      StWrite: begin
        write_ready_o = 1'b1;
        if (write_valid_i) begin
          sram_ce_o    = in_range;
          sram_we_o    = in_range;
          sram_addr_o  = waddr_q[WAW-1:0];
          sram_be_o    = burst_q ? '1 : write_strb_i;
          sram_wdata_o = write_data_i;
          waddr_d      = waddr_q + XW'(1);
          remaining_d  = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StIdle;
        end
      end
      StRead: begin
        if (slot_free && remaining_q != 16'd0) begin
          issue       = 1'b1;
          sram_ce_o   = in_range;
          sram_addr_o = waddr_q[WAW-1:0];
          waddr_d     = waddr_q + XW'(1);
          remaining_d = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!inflight_q && count_d == 2'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      waddr_q         <= '0;
      remaining_q     <= '0;
      burst_q         <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_zero_q <= 1'b0;
      fifo_q[0]       <= '0;
      fifo_q[1]       <= '0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      count_q         <= '0;
    end else begin
      state_q         <= state_d;
      waddr_q         <= waddr_d;
      remaining_q     <= remaining_d;
      burst_q         <= burst_d;
      inflight_q      <= issue;
      inflight_zero_q <= issue & ~in_range;
      count_q         <= count_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

endmodule

// File: tb/tb_osd_mam_sram_resp.sv
// Bench for osd_mam_sram_resp: random and directed MAM traffic against a word-level memory model.
module tb_osd_mam_sram_resp;

  localparam int DW   = 32;
  localparam int MEM  = 64;
  localparam int BASE = 64;
  localparam int AWD  = 7;
  localparam int NW   = 16;
`ifdef OSD_MAM_SRAM_BOUNDS_EN
  localparam bit BOUNDS = 1'b1;
`else
  localparam bit BOUNDS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0, req_ready, req_rw = 1'b0, req_burst = 1'b0;
  logic [AWD-1:0] req_addr = '0;
  logic [15:0]   req_size = '0;
  logic          write_valid = 1'b0, write_ready;
  logic [31:0]   write_data = '0;
  logic [3:0]    write_strb = '0;
  logic          read_valid, read_ready = 1'b0;
  logic [31:0]   read_data;
  logic          sram_ce, sram_we;
  logic [3:0]    sram_addr, sram_be;
  logic [31:0]   sram_wdata, sram_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  osd_mam_sram_resp #(
    .DATA_WIDTH(DW), .MEM_SIZE(MEM), .ADDR_BASE(BASE), .AW(AWD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_addr_i(req_addr), .req_burst_i(req_burst), .req_size_i(req_size),
    .write_valid_i(write_valid), .write_data_i(write_data), .write_strb_i(write_strb),
    .write_ready_o(write_ready),
    .read_valid_o(read_valid), .read_data_o(read_data), .read_ready_i(read_ready),
    .sram_ce_o(sram_ce), .sram_we_o(sram_we), .sram_addr_o(sram_addr), .sram_be_o(sram_be),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  // Memory macro the DUT talks to.
  logic [31:0] sram_mem [NW];
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct { int cyc; int addr; logic [3:0] be; logic [31:0] data; } wr_t;
  wr_t         wlog[$];
  logic [31:0] rd_q[$];
  int          rd_cyc[$];
  int          n_issue = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (sram_ce && sram_we) wlog.push_back('{cyc, int'(sram_addr), sram_be, sram_wdata});
      if (sram_ce && !sram_we) n_issue <= n_issue + 1;
      if (read_valid && read_ready) begin
        rd_q.push_back(read_data);
        rd_cyc.push_back(cyc);
      end
    end
  end

  // Reference model: memory seen as words relative to BASE.
  logic [31:0] ref_mem [NW];
  logic [31:0] wq[$];

  function automatic int rel_word(input int addr);
    return (addr - BASE) >>> 2;
  endfunction
  function automatic bit in_rng(input int w);
    return !BOUNDS || (w >= 0 && w < NW);
  endfunction
  function automatic int wrap(input int w);
    return ((w % NW) + NW) % NW;
  endfunction
  function automatic logic [31:0] model_read(input int w);
    return in_rng(w) ? ref_mem[wrap(w)] : 32'h0;
  endfunction
  task automatic model_write(input int w, input logic [3:0] be, input logic [31:0] d);
    if (in_rng(w))
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[wrap(w)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic send_req(input bit rw, input int addr, input bit burst, input int size,
                          input logic [3:0] strb);
    bit ok = 1'b0;
    req_valid = 1'b1; req_rw = rw; req_addr = AWD'(addr); req_burst = burst;
    req_size = 16'(size); write_strb = strb;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL req_accept: req_ready never seen high"); end
  endtask

  task automatic drive_beat(input logic [31:0] d);
    bit ok = 1'b0;
    write_valid = 1'b1; write_data = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (write_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    write_valid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL write_beat: write_ready never seen high"); end
  endtask

  task automatic run_write(input int addr, input bit burst, input int size, input logic [3:0] strb);
    int w0 = rel_word(addr);
    send_req(1'b1, addr, burst, size, strb);
    for (int i = 0; i < wq.size(); i++) begin
      drive_beat(wq[i]);
      model_write(w0 + i, burst ? 4'hF : strb, wq[i]);
    end
  endtask

  task automatic run_read(input int addr, input bit burst, input int size, input bit rnd);
    bit done = 1'b0;
    read_ready = 1'b1;
    send_req(1'b0, addr, burst, size, 4'hF);
    for (int i = 0; i < 400; i++) begin
      read_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (req_ready) begin done = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (done) begin @(posedge clk); #1; end
    read_ready = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL read_done: request never completed"); end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++;
    if (write_ready !== 1'b0) begin errors++; $display("FAIL reset_write_ready: got %b want 0", write_ready); end
    checks++;
    if ({read_valid, read_data} !== 33'h0) begin
      errors++; $display("FAIL reset_read: got valid %b data %h want 0", read_valid, read_data);
    end
    checks++;
    if ({sram_ce, sram_we, sram_addr, sram_be, sram_wdata} !== 42'h0) begin
      errors++; $display("FAIL reset_sram: got ce %b we %b addr %h be %h wdata %h want all 0",
                         sram_ce, sram_we, sram_addr, sram_be, sram_wdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_write;
    int n0 = wlog.size();
    wq = '{32'hAABBCCDD};
    run_write(BASE + 8, 1'b0, 0, 4'b0011);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL single_req_ready: got %b want 1", req_ready); end
    checks++;
    if (write_ready !== 1'b0) begin errors++; $display("FAIL single_idle_wready: got %b want 0", write_ready); end
    checks++;
    if (wlog.size() - n0 != 1) begin
      errors++; $display("FAIL single_count: got %0d writes want 1", wlog.size() - n0);
    end else begin
      checks++;
      if (wlog[n0].addr != 2 || wlog[n0].be !== 4'b0011 || wlog[n0].data !== 32'hAABBCCDD) begin
        errors++; $display("FAIL single_beat: got addr %0d be %b data %h want 2 0011 aabbccdd",
                           wlog[n0].addr, wlog[n0].be, wlog[n0].data);
      end
    end
  endtask

  task automatic test_burst_write;
    int n0 = wlog.size();
    wq = '{32'h1, 32'h2, 32'h3, 32'h4};
    run_write(BASE, 1'b1, 4, 4'hF);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL burst_wr_idle: got %b want 1", req_ready); end
    checks++;
    if (wlog.size() - n0 != 4) begin
      errors++; $display("FAIL burst_wr_count: got %0d want 4", wlog.size() - n0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[n0+i].addr != i || wlog[n0+i].be !== 4'hF || wlog[n0+i].data !== 32'(i + 1) ||
            wlog[n0+i].cyc != wlog[n0].cyc + i) begin
          errors++; $display("FAIL burst_wr_beat%0d: got addr %0d be %h data %h cyc+%0d want %0d f %0d +%0d",
                             i, wlog[n0+i].addr, wlog[n0+i].be, wlog[n0+i].data,
                             wlog[n0+i].cyc - wlog[n0].cyc, i, i + 1, i);
        end
      end
    end
  endtask

  task automatic test_burst_read_stall;
    int i0 = n_issue;
    int r0 = rd_q.size();
    bit done = 1'b0;
    read_ready = 1'b0;
    send_req(1'b0, BASE, 1'b1, 4, 4'hF);
    read_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (n_issue - i0 != 2) begin errors++; $display("FAIL stall_issue: got %0d reads want 2", n_issue - i0); end
    checks++;
    if (read_valid !== 1'b1 || rd_q.size() != r0) begin
      errors++; $display("FAIL stall_hold: got valid %b pops %0d want 1 0", read_valid, rd_q.size() - r0);
    end
    read_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin done = 1'b1; break; end
    end
    @(posedge clk); #1;
    read_ready = 1'b0;
    checks++;
    if (!done || rd_q.size() - r0 != 4) begin
      errors++; $display("FAIL stall_count: got %0d beats done %b want 4 1", rd_q.size() - r0, done);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_q[r0+i] !== model_read(i) || rd_cyc[r0+i] != rd_cyc[r0] + i) begin
          errors++; $display("FAIL stall_beat%0d: got %h at +%0d want %h at +%0d",
                             i, rd_q[r0+i], rd_cyc[r0+i] - rd_cyc[r0], model_read(i), i);
        end
      end
    end
  endtask

  task automatic test_zero_size;
    int i0 = n_issue;
    int r0 = rd_q.size();
    run_read(BASE + 4, 1'b1, 0, 1'b0);
    checks++;
    if (rd_q.size() - r0 != 1 || n_issue - i0 != 1) begin
      errors++; $display("FAIL zero_size_count: got %0d beats %0d reads want 1 1",
                         rd_q.size() - r0, n_issue - i0);
    end else begin
      checks++;
      if (rd_q[r0] !== model_read(1)) begin
        errors++; $display("FAIL zero_size_data: got %h want %h", rd_q[r0], model_read(1));
      end
    end
  endtask

  task automatic test_bounds;
    int n0 = wlog.size();
    int exp_addr[$];
    int i0, r0;
    for (int i = 0; i < 4; i++) if (in_rng(15 + i)) exp_addr.push_back(wrap(15 + i));
    wq = '{$urandom, $urandom, $urandom, $urandom};
    run_write(BASE + 60, 1'b1, 4, 4'hF);
    checks++;
    if (wlog.size() - n0 != exp_addr.size()) begin
      errors++; $display("FAIL bounds_wr_count: got %0d want %0d", wlog.size() - n0, exp_addr.size());
    end else begin
      for (int i = 0; i < exp_addr.size(); i++) begin
        checks++;
        if (wlog[n0+i].addr != exp_addr[i]) begin
          errors++; $display("FAIL bounds_wr_addr%0d: got %0d want %0d", i, wlog[n0+i].addr, exp_addr[i]);
        end
      end
    end
    i0 = n_issue;
    r0 = rd_q.size();
    run_read(0, 1'b0, 0, 1'b0);
    checks++;
    if (rd_q.size() - r0 != 1 || n_issue - i0 != (in_rng(rel_word(0)) ? 1 : 0)) begin
      errors++; $display("FAIL bounds_below_base: got %0d beats %0d reads want 1 %0d",
                         rd_q.size() - r0, n_issue - i0, in_rng(rel_word(0)) ? 1 : 0);
    end else begin
      checks++;
      if (rd_q[r0] !== model_read(rel_word(0))) begin
        errors++; $display("FAIL bounds_below_data: got %h want %h", rd_q[r0], model_read(rel_word(0)));
      end
    end
  endtask

  task automatic test_random;
    wq.delete();
    for (int i = 0; i < NW; i++) wq.push_back($urandom);
    run_write(BASE, 1'b1, NW, 4'hF);
    for (int t = 0; t < 24; t++) begin
      bit rw = 1'($urandom_range(0, 1));
      int w = $urandom_range(0, NW - 1);
      bit burst = 1'($urandom_range(0, 1));
      int size = $urandom_range(0, 6);
      int nb = burst ? ((size == 0) ? 1 : size) : 1;
      logic [3:0] strb = 4'($urandom_range(1, 15));
      if (rw) begin
        int n0 = wlog.size();
        int exp_n = 0;
        wq.delete();
        for (int i = 0; i < nb; i++) begin
          wq.push_back($urandom);
          if (in_rng(w + i)) exp_n++;
        end
        run_write(BASE + 4 * w, burst, size, strb);
        checks++;
        if (wlog.size() - n0 != exp_n) begin
          errors++; $display("FAIL rand_wr%0d_count: got %0d want %0d", t, wlog.size() - n0, exp_n);
        end
      end else begin
        int r0 = rd_q.size();
        run_read(BASE + 4 * w, burst, size, 1'b1);
        checks++;
        if (rd_q.size() - r0 != nb) begin
          errors++; $display("FAIL rand_rd%0d_count: got %0d want %0d", t, rd_q.size() - r0, nb);
        end else begin
          for (int i = 0; i < nb; i++) begin
            checks++;
            if (rd_q[r0+i] !== model_read(w + i)) begin
              errors++; $display("FAIL rand_rd%0d_beat%0d: got %h want %h",
                                 t, i, rd_q[r0+i], model_read(w + i));
            end
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst;
    int r0 = rd_q.size();
    bit hit = 1'b0;
    read_ready = 1'b1;
    send_req(1'b0, BASE, 1'b1, 8, 4'hF);
    for (int i = 0; i < 30; i++) begin
      if (rd_q.size() >= r0 + 1) begin hit = 1'b1; break; end
      @(posedge clk); #1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL midrst_first_beat: no beat delivered"); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (read_valid !== 1'b0 || req_ready !== 1'b1 || sram_ce !== 1'b0) begin
      errors++; $display("FAIL midrst_abort: got valid %b ready %b ce %b want 0 1 0",
                         read_valid, req_ready, sram_ce);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    read_ready = 1'b0;
    @(posedge clk); #1;
    r0 = rd_q.size();
    run_read(BASE, 1'b1, 4, 1'b0);
    checks++;
    if (rd_q.size() - r0 != 4) begin
      errors++; $display("FAIL midrst_count: got %0d want 4", rd_q.size() - r0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (rd_q[r0+i] !== model_read(i)) begin
          errors++; $display("FAIL midrst_beat%0d: got %h want %h", i, rd_q[r0+i], model_read(i));
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_burst_read_stall();
    test_zero_size();
    test_bounds();
    test_random();
    test_reset_mid_burst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
